// File: rtl/i2s_pkg.sv
//==============================================================================
// i2s_pkg: shared constants and types for the I2S slave transmitter
// Revision: 1.0
//==============================================================================
`default_nettype none

package i2s_pkg;

  localparam int DW_DEFAULT    = 16;
  localparam int DEPTH_DEFAULT = 4;
  localparam int SYNC_STAGES   = 2;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

endpackage

`default_nettype wire

// File: rtl/i2s_frame_fifo.sv
//==============================================================================
// i2s_frame_fifo: synchronous stereo-frame FIFO with show-ahead read port
// Revision: 1.0
//==============================================================================
`default_nettype none

module i2s_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_one   = {{c_aw{1'b0}}, 1'b1};
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [c_aw:0]    w_level;
  logic             w_push;
  logic             w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (w_level == c_depth);
  assign o_empty = (w_level == '0);
  assign o_level = w_level;
  assign o_rdata = r_mem[r_rd_ptr[c_aw-1:0]];

  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_one;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/i2s_tx_slave.sv
//==============================================================================
// i2s_tx_slave: I2S transmitter slaved to an external SCK/WS master
// Revision: 1.0
//==============================================================================
`default_nettype none

module i2s_tx_slave
  import i2s_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [DW-1:0]          s_left_i,
  input  logic [DW-1:0]          s_right_i,
  input  logic                   sck_i,
  input  logic                   ws_i,
  output logic                   sd_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   underrun_o
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic                   r_sck_d;
  chan_e                  r_ws_d;
  logic [DW-1:0]          r_sr;
  logic [DW-1:0]          r_hold;
  logic                   r_sd;
  logic                   r_active;
  logic                   r_underrun;

  logic                   w_sck_s;
  chan_e                  w_ws_s;
  logic                   w_fall;
  logic                   w_slot_edge;
  logic                   w_left_edge;
  logic                   w_right_edge;
  logic                   w_go;
  logic                   w_avail;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [2*DW-1:0]        w_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sck_d    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
      r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], ws_i};
      r_sck_d    <= w_sck_s;
    end
  end

  assign w_sck_s      = r_sck_sync[SYNC_STAGES-1];
  assign w_ws_s       = chan_e'(r_ws_sync[SYNC_STAGES-1]);
  assign w_fall       = r_sck_d && !w_sck_s;
  assign w_slot_edge  = w_fall && (w_ws_s != r_ws_d);
  assign w_left_edge  = w_slot_edge && (w_ws_s == LEFT);
  assign w_right_edge = w_slot_edge && (w_ws_s == RIGHT);

  // A left transition with en_i high both activates an idle block and serves the frame.
  assign w_go    = en_i && w_left_edge;
  // A flush coinciding with the left transition makes the slot an underrun.
  assign w_avail = !w_empty && !flush_i;
  assign w_pop   = w_go && w_avail;

  assign s_ready_o = !w_full && !flush_i;
  assign w_push    = s_valid_i && s_ready_o;

  i2s_frame_fifo #(
    .WIDTH (2*DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_flush (flush_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({s_left_i, s_right_i}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ws_d     <= LEFT;
      r_sr       <= '0;
      r_hold     <= '0;
      r_sd       <= 1'b0;
      r_active   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_fall) r_ws_d <= w_ws_s;

      if (!en_i) begin
        r_active <= 1'b0;
        r_sr     <= '0;
        r_hold   <= '0;
        r_sd     <= 1'b0;
      end else if (w_fall) begin
        r_sd <= r_sr[DW-1];
        if (w_go) begin
          r_active <= 1'b1;
          if (w_avail) begin
            r_sr   <= w_rdata[2*DW-1:DW];
            r_hold <= w_rdata[DW-1:0];
          end else begin
            r_sr       <= '0;
            r_hold     <= '0;
            r_underrun <= 1'b1;
          end
        end else if (w_right_edge) begin
          r_sr <= r_hold;
        end else begin
          r_sr <= {r_sr[DW-2:0], 1'b0};
        end
      end
    end
  end

  // Gating with en_i drops the line in the same cycle enable is removed.
  assign sd_o       = r_sd && r_active && en_i;
  assign underrun_o = r_underrun;

endmodule

`default_nettype wire
